// File: rtl/joypad_pkg.sv
// rtl/joypad_pkg.sv - shared constants and types for the joypad scanner
//
// Purpose: scan FSM state encoding, button bit positions within the
//          buttons vector, and the default timing parameters.
// Ports:   none (package).
package joypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } scan_state_t;

  // Bit positions in the active-high buttons vector (4021 shift order).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEFAULT_CLK_DIV     = 96;
  localparam int DEFAULT_SCAN_PERIOD = 357000;

endpackage

// File: rtl/joypad_shift_emu.sv
// rtl/joypad_shift_emu.sv - 4021-style parallel-load shift register facing the NES core
//
// Purpose: presents the committed button state to the core as the original
//          controller would: parallel load while strobe is high, shift right
//          on each falling edge of the core's controller clock, ones fill in.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   buttons       active-high button state to load
//   nes_strobe    load enable from the core (load wins over shift)
//   nes_clock     shift clock from the core (same clock domain)
//   nes_data      active-high serial bit to the core (emu[0])
module joypad_shift_emu (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       nes_strobe,
  input  logic       nes_clock,
  output logic       nes_data
);

  logic [7:0] emu;
  logic       clock_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      emu        <= 8'h00;
      clock_prev <= 1'b0;
    end else begin
      clock_prev <= nes_clock;
      if (nes_strobe) begin
        emu <= buttons;
      end else if (clock_prev && !nes_clock) begin
        emu <= {1'b1, emu[7:1]};
      end
    end
  end

  assign nes_data = emu[0];

endmodule

// File: rtl/joypad_scanner.sv
// rtl/joypad_scanner.sv - periodic NES controller scanner with 4021 emulation toward the core
//
// Purpose: periodically latches and clocks out a physical NES pad, commits
//          the active-high button state, and re-serialises it to the core.
//          Optional macro JOYPAD_DEBOUNCE_EN: commit only when two
//          consecutive scans agree.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   pad_data       async serial data from the pad, low = pressed
//   pad_latch      latch pulse to the pad
//   pad_clock      shift clock to the pad, idles high
//   buttons        committed active-high button state
//   buttons_valid  one-cycle pulse when buttons is updated
//   nes_strobe     controller strobe from the core
//   nes_clock      controller clock from the core
//   nes_data       serial button bit to the core
module joypad_scanner
  import joypad_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int SCAN_PERIOD = DEFAULT_SCAN_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clock,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  input  logic       nes_strobe,
  input  logic       nes_clock,
  output logic       nes_data
);

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int PER_W = $clog2(SCAN_PERIOD + 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SCAN_PERIOD - 1);

  scan_state_t      state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       sync;
  logic [7:0]       shift;
  // Set by reset so the first scan starts right away instead of waiting a period.
  logic             kick;
  logic             phase_end;
  logic             commit;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0]       prev_shift;
`endif

  always_comb begin
    state_nx  = state;
    phase_end = (div_cnt == PHASE_LAST);
    case (state)
      IDLE:    if (kick || per_cnt == PER_LAST) state_nx = LATCH;
      LATCH:   if (div_cnt == LATCH_LAST) state_nx = CLK_LO;
      CLK_LO:  if (phase_end) state_nx = CLK_HI;
      CLK_HI:  if (phase_end) state_nx = (bit_idx == 3'd7) ? DONE : CLK_LO;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Commit on the edge into DONE so buttons and buttons_valid appear together
  // during the DONE cycle; shift[7] was captured a half-period earlier.
`ifdef JOYPAD_DEBOUNCE_EN
  assign commit = (state == CLK_HI) && (state_nx == DONE) && (shift == prev_shift);
`else
  assign commit = (state == CLK_HI) && (state_nx == DONE);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      per_cnt       <= '0;
      bit_idx       <= 3'd0;
      sync          <= 2'b00;
      shift         <= 8'h00;
      kick          <= 1'b1;
      buttons       <= 8'h00;
      buttons_valid <= 1'b0;
      pad_latch     <= 1'b0;
      pad_clock     <= 1'b1;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_shift    <= 8'h00;
`endif
    end else begin
      state <= state_nx;
      sync  <= {sync[0], pad_data};
      // Pad pins are registered from the next state so they are glitch-free
      // yet still coincide with the state they belong to.
      pad_latch <= (state_nx == LATCH);
      pad_clock <= (state_nx != CLK_LO);

      if (state == IDLE || state_nx != state) div_cnt <= '0;
      else                                    div_cnt <= div_cnt + 1'b1;

      if (state == IDLE && state_nx == LATCH) begin
        kick    <= 1'b0;
        per_cnt <= '0;
      end else if (per_cnt == PER_LAST) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_cnt + 1'b1;
      end

      if (state == LATCH)                 bit_idx <= 3'd0;
      else if (state == CLK_HI && phase_end) bit_idx <= bit_idx + 1'b1;

      if (state == CLK_LO && phase_end) shift[bit_idx] <= sync[1];

      buttons_valid <= commit;
      if (commit) buttons <= ~shift;
`ifdef JOYPAD_DEBOUNCE_EN
      if (state == CLK_HI && state_nx == DONE) prev_shift <= shift;
`endif
    end
  end

  joypad_shift_emu u_emu (
    .clock      (clock),
    .reset      (reset),
    .buttons    (buttons),
    .nes_strobe (nes_strobe),
    .nes_clock  (nes_clock),
    .nes_data   (nes_data)
  );

endmodule

// File: tb/tb_joypad_scanner.sv
// tb/tb_joypad_scanner.sv - directed self-checking bench for joypad_scanner (CLK_DIV=4, SCAN_PERIOD=100)
//
// Purpose: cycle-numbered directed scenarios; cycle N is the state after the
//          Nth rising edge following reset release. A small pad model drives
//          pad_data from a raw bit pattern (bit i = raw level for button i).
// Ports:   none (top-level bench).
module tb_joypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data = 1'b1;
  logic       nes_strobe = 1'b0;
  logic       nes_clock = 1'b1;
  logic       pad_latch, pad_clock, buttons_valid, nes_data;
  logic [7:0] buttons;

  joypad_scanner #(.CLK_DIV(4), .SCAN_PERIOD(100)) dut (
    .clock         (clock),
    .reset         (reset),
    .pad_data      (pad_data),
    .pad_latch     (pad_latch),
    .pad_clock     (pad_clock),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .nes_strobe    (nes_strobe),
    .nes_clock     (nes_clock),
    .nes_data      (nes_data)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         scan_start = -1000;
  logic       prev_latch = 1'b0;
  logic [7:0] pat = 8'hFF;
  int         valid_cnt = 0;
  int         valid_cyc = -1;
  logic [7:0] valid_btn = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, track latch/valid, drive the pad.
  // The pad presents bit 0 from latch start and advances on each rising
  // pad_clock (start of CLK_HI), i.e. bit i from scan cycle 8i+5.
  task automatic step();
    int ph;
    int b;
    @(posedge clock);
    #1;
    cyc++;
    if (pad_latch && !prev_latch) scan_start = cyc;
    prev_latch = pad_latch;
    if (buttons_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      valid_btn = buttons;
    end
    ph = cyc - scan_start + 1;
    if (ph >= 1 && ph <= 72) begin
      b = (ph <= 12) ? 0 : (ph - 5) / 8;
      if (b > 7) b = 7;
      pad_data = pat[b];
    end else begin
      pad_data = 1'b1;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_cnt, lat_first, lat_last, lo_len, lo_pulses, lo_min, lo_max;
    logic [7:0] exp_btn;

    repeat (3) @(posedge clock);
    #1;
    check("rst_pad_latch", pad_latch, 1'b0);
    check("rst_pad_clock", pad_clock, 1'b1);
    check("rst_buttons", buttons, 8'h00);
    check("rst_valid", buttons_valid, 1'b0);
    check("rst_nes_data", nes_data, 1'b0);
    reset = 1'b0;
    cyc = 0;

`ifdef JOYPAD_DEBOUNCE_EN
    // First scan differs from the reset-cleared history: no commit.
    pat = 8'hFF;
    run_to(80);
    check("db_first_scan_nocommit", valid_cnt, 0);
    run_to(180);
    check("db_second_scan_valid_cyc", valid_cyc, 173);
    check("db_second_scan_buttons", buttons, 8'h00);
    pat = 8'hFE;
    run_to(280);
    check("db_single_scan_nocommit", valid_cnt, 1);
    check("db_single_scan_buttons", buttons, 8'h00);
    run_to(380);
    check("db_two_scans_valid_cyc", valid_cyc, 373);
    check("db_two_scans_buttons", buttons, 8'h01);
`else
    // Scan 1: all released.
    lat_cnt = 0; lat_first = -1; lat_last = -1;
    lo_len = 0; lo_pulses = 0; lo_min = 1000; lo_max = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (pad_latch) begin
        lat_cnt++;
        if (lat_first < 0) lat_first = cyc;
        lat_last = cyc;
      end
      if (!pad_clock) begin
        lo_len++;
      end else if (lo_len > 0) begin
        lo_pulses++;
        if (lo_len < lo_min) lo_min = lo_len;
        if (lo_len > lo_max) lo_max = lo_len;
        lo_len = 0;
      end
    end
    check("latch_first", lat_first, 1);
    check("latch_last", lat_last, 8);
    check("latch_len", lat_cnt, 8);
    check("clk_lo_pulses", lo_pulses, 8);
    check("clk_lo_min", lo_min, 4);
    check("clk_lo_max", lo_max, 4);
    check("scan1_valid_cnt", valid_cnt, 1);
    check("scan1_valid_cyc", valid_cyc, 73);
    check("scan1_buttons", valid_btn, 8'h00);

    // Scan 2: A and Up pressed (raw 0,1,1,1,0,1,1,1).
    pat = 8'hEE;
    valid_cnt = 0;
    run_to(180);
    check("scan2_latch_start", scan_start, 101);
    check("scan2_valid_cnt", valid_cnt, 1);
    check("scan2_valid_cyc", valid_cyc, 173);
    check("scan2_valid_buttons", valid_btn, 8'h11);
    check("scan2_buttons", buttons, 8'h11);

    // Serial readout of 8'h11; scan 3 (all released) commits 00 mid-readout.
    pat = 8'hFF;
    exp_btn = 8'h11;
    run_to(254);
    nes_strobe = 1'b1;
    step();
    step();
    nes_strobe = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("serial_bit%0d", k), nes_data, (k < 8) ? exp_btn[k] : 1'b1);
      nes_clock = 1'b0;
      step();
      step();
      nes_clock = 1'b1;
      step();
      step();
    end
    check("serial_after_10", nes_data, 1'b1);
    check("scan3_committed_00", buttons, 8'h00);
    check("scan3_valid_cyc", valid_cyc, 273);

    // Strobe held across a commit and a clock fall.
    pat = 8'hEE;
    run_to(360);
    nes_strobe = 1'b1;
    run_to(373);
    check("scan4_buttons_at_done", buttons, 8'h11);
    check("scan4_valid_at_done", buttons_valid, 1'b1);
    check("load_before_visible", nes_data, 1'b0);
    step();
    check("load_next_cycle", nes_data, 1'b1);
    nes_clock = 1'b0;
    step();
    step();
    check("strobe_priority", nes_data, 1'b1);
    nes_clock = 1'b1;
    step();
    nes_strobe = 1'b0;
    step();
    nes_clock = 1'b0;
    step();
    step();
    check("shift_after_strobe", nes_data, 1'b0);
    nes_clock = 1'b1;

    // Reset during CLK_LO of bit 3 of scan 5 (all pressed).
    pat = 8'h00;
    valid_cnt = 0;
    run_to(434);
    check("abort_in_clk_lo", pad_clock, 1'b0);
    reset = 1'b1;
    step();
    step();
    check("abort_pad_latch", pad_latch, 1'b0);
    check("abort_pad_clock", pad_clock, 1'b1);
    check("abort_buttons", buttons, 8'h00);
    check("abort_valid", buttons_valid, 1'b0);
    check("abort_nes_data", nes_data, 1'b0);
    check("abort_no_commit", valid_cnt, 0);
    reset = 1'b0;
    cyc = 0;
    step();
    check("restart_latch", pad_latch, 1'b1);
    check("restart_scan_start", scan_start, 1);
    run_to(80);
    check("restart_valid_cnt", valid_cnt, 1);
    check("restart_valid_cyc", valid_cyc, 73);
    check("restart_buttons", buttons, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
